mem_arbiter_n: RTL and testbench

MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/rr_picker.sv | 29 ++
 rtl/mem_arbiter_n.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter_n.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the urgent-first memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HP   = 2'd1,
    ST_LP   = 2'd2,
    ST_PRE  = 2'd3
  } arb_state_e;

  // grant_id reserves code 0 for "no owner", so it must encode NREQ+1 values.
  function automatic int id_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select over requesters 1..NREQ-1, starting at ptr_i.
module rr_picker #(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:1]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:1]  gnt_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ - 1; k++) begin
      idx = int'(ptr_i) + k;
      // Candidates wrap from NREQ-1 back to 1; requester 0 is never a candidate.
      if (idx >= NREQ) idx = idx - (NREQ - 1);
      if (!found && idx >= 1 && idx < NREQ && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-way memory arbiter: requester 0 has absolute priority and may preempt
// a bounded low-priority grant; requesters 1..NREQ-1 share round-robin.
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int MAX_HOLD = 2,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  // req is a level request; done[i] ends the access only when i owns the grant.
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          done,
  input  logic                     preempt_en,
  output logic [NREQ-1:0]          grant,
  output logic [id_w(NREQ)-1:0]    grant_id,
  output logic                     preempted,
  output logic [CNT_W-1:0]         nb_interrupts,
  output arb_state_e               dbg_state,
  output logic [idx_w(NREQ)-1:0]   dbg_rr_ptr
);

  localparam int IDX_W  = idx_w(NREQ);
  localparam int ID_W   = id_w(NREQ);
  localparam int HOLD_W = 4;
  localparam logic [HOLD_W-1:0] MAX_HOLD_V = HOLD_W'(MAX_HOLD);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   nb_int_q, nb_int_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               preempted_q, preempted_d;

  logic [NREQ-1:1]    lp_onehot;
  logic [IDX_W-1:0]   lp_win;
  arb_state_e         arb_state;
  logic [IDX_W-1:0]   arb_owner;
  logic [HOLD_W-1:0]  arb_hold;
  logic [IDX_W-1:0]   arb_ptr;
  logic               rearb;

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req_i (req[NREQ-1:1]),
    .ptr_i (rr_ptr_q),
    .gnt_o (lp_onehot)
  );

  // Outcome of a fresh arbitration, used by every state that releases.
  always_comb begin
    lp_win    = '0;
    arb_state = ST_IDLE;
    arb_owner = '0;
    arb_hold  = '0;
    arb_ptr   = rr_ptr_q;
    for (int i = 1; i < NREQ; i++) begin
      if (lp_onehot[i]) lp_win = IDX_W'(i);
    end
    if (req[0]) begin
      arb_state = ST_HP;
    end else if (|lp_onehot) begin
      arb_state = ST_LP;
      arb_owner = lp_win;
      arb_hold  = HOLD_W'(1);
      arb_ptr   = (lp_win == IDX_W'(NREQ - 1)) ? IDX_W'(1) : lp_win + IDX_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    rr_ptr_d = rr_ptr_q;
    nb_int_d = nb_int_q;
    rearb    = 1'b0;
    case (state_q)
      ST_IDLE: rearb = 1'b1;
      ST_HP:   rearb = done[0];
      ST_LP: begin
        if (done[owner_q]) begin
          rearb = 1'b1;
        end else if (preempt_en && req[0] && (hold_q < MAX_HOLD_V)) begin
          state_d = ST_PRE;
          owner_d = '0;
          hold_d  = HOLD_W'(1);
          if (nb_int_q != '1) nb_int_d = nb_int_q + CNT_W'(1);
        end else if (hold_q == MAX_HOLD_V) begin
          rearb = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_PRE: begin
        if (done[0] || (hold_q == MAX_HOLD_V)) rearb = 1'b1;
        else                                   hold_d = hold_q + HOLD_W'(1);
      end
      default: rearb = 1'b1;
    endcase
    // The preempted requester is dropped; it must win a later arbitration.
    if (rearb) begin
      state_d  = arb_state;
      owner_d  = arb_owner;
      hold_d   = arb_hold;
      rr_ptr_d = arb_ptr;
    end
  end

  always_comb begin
    grant_d     = '0;
    grant_id_d  = '0;
    preempted_d = (state_d == ST_PRE);
    if (state_d != ST_IDLE) begin
      grant_d[owner_d] = 1'b1;
      grant_id_d       = ID_W'(owner_d) + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      hold_q      <= '0;
      rr_ptr_q    <= IDX_W'(1);
      nb_int_q    <= '0;
      grant_q     <= '0;
      grant_id_q  <= '0;
      preempted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      rr_ptr_q    <= rr_ptr_d;
      nb_int_q    <= nb_int_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      preempted_q <= preempted_d;
    end
  end

  assign grant         = grant_q;
  assign grant_id      = grant_id_q;
  assign preempted     = preempted_q;
  assign nb_interrupts = nb_int_q;
  assign dbg_state     = state_q;
  assign dbg_rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n (NREQ=3, MAX_HOLD=2): directed scenarios plus a
// randomized run against an owner/hold-count reference model.
module tb_mem_arbiter_n;
  import mem_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int MAXH = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] req, done;
  logic       preempt_en;
  logic [2:0] grant, grant_s;
  logic [1:0] grant_id, grant_id_s;
  logic       preempted, preempted_s;
  logic [15:0] nb_interrupts;
  logic [1:0]  nb_sat;
  arb_state_e  dbg_state, dbg_state_s;
  logic [1:0]  dbg_rr_ptr, dbg_rr_ptr_s;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: owner (-1 idle), preempting flag, cycles held, rr pointer, preemptions
  int m_owner, m_hold, m_ptr, m_cnt;
  bit m_pre;

  always #5 clk = ~clk;

  mem_arbiter_n #(.NREQ(3), .MAX_HOLD(2), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done), .preempt_en(preempt_en),
    .grant(grant), .grant_id(grant_id), .preempted(preempted),
    .nb_interrupts(nb_interrupts), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // Narrow-counter twin sharing all inputs, so saturation is reached quickly.
  mem_arbiter_n #(.NREQ(3), .MAX_HOLD(2), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done), .preempt_en(preempt_en),
    .grant(grant_s), .grant_id(grant_id_s), .preempted(preempted_s),
    .nb_interrupts(nb_sat), .dbg_state(dbg_state_s), .dbg_rr_ptr(dbg_rr_ptr_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; done = '0; preempt_en = 1'b0;
    tick();
    reset_n = 1'b1;
    m_owner = -1; m_pre = 0; m_hold = 0; m_ptr = 1; m_cnt = 0;
  endtask

  task automatic model_arbitrate();
    m_pre = 0; m_owner = -1; m_hold = 0;
    if (req[0]) begin
      m_owner = 0;
    end else begin
      for (int k = 0; k < NREQ - 1; k++) begin
        int c;
        c = ((m_ptr - 1 + k) % (NREQ - 1)) + 1;
        if (m_owner < 0 && req[c]) begin
          m_owner = c; m_hold = 1; m_ptr = (c % (NREQ - 1)) + 1;
        end
      end
    end
  endtask

  task automatic model_step();
    bit release_now;
    release_now = 0;
    if (!reset_n) begin
      m_owner = -1; m_pre = 0; m_hold = 0; m_ptr = 1; m_cnt = 0;
      return;
    end
    if (m_owner < 0)        release_now = 1;
    else if (m_pre)         begin if (done[0] || m_hold == MAXH) release_now = 1; else m_hold++; end
    else if (m_owner == 0)  release_now = done[0];
    else if (done[m_owner]) release_now = 1;
    else if (preempt_en && req[0] && m_hold < MAXH) begin
      m_owner = 0; m_pre = 1; m_hold = 1; m_cnt++;
    end
    else if (m_hold == MAXH) release_now = 1;
    else m_hold++;
    if (release_now) model_arbitrate();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 3'b111; done = '0; preempt_en = 1'b1;
    tick(); tick();
    n_tests++;
    if (grant !== 3'b000 || grant_id !== 2'd0 || preempted !== 1'b0 || nb_interrupts !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b id=%0d pre=%b nb=%0d, want 000/0/0/0", grant, grant_id, preempted, nb_interrupts);
    end
    n_tests++;
    if (dbg_state !== ST_IDLE || dbg_rr_ptr !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d rr_ptr=%0d, want 0/1", dbg_state, dbg_rr_ptr);
    end
    reset_n = 1'b1;
    tick();
    n_tests++;
    if (grant !== 3'b001 || grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_first_arb: grant=%b id=%0d, want 001/1", grant, grant_id);
    end
  endtask

  task automatic test_hp_release_idle();
    req = 3'b000; done = 3'b001;
    tick();
    n_tests++;
    if (grant !== 3'b000 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL hp_done_idle: grant=%b id=%0d, want 000/0", grant, grant_id);
    end
    done = '0;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g[6];
    logic [1:0] exp_p[6];
    exp_g = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b010, 3'b010};
    exp_p = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2};
    do_reset();
    req = 3'b110;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (grant !== exp_g[i] || dbg_rr_ptr !== exp_p[i]) begin
        n_fail++;
        $display("FAIL rr_step%0d: grant=%b ptr=%0d, want %b/%0d", i, grant, dbg_rr_ptr, exp_g[i], exp_p[i]);
      end
    end
    req = 3'b000;
    tick();
    n_tests++;
    if (grant !== 3'b000) begin
      n_fail++;
      $display("FAIL rr_to_idle: grant=%b, want 000", grant);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    preempt_en = 1'b1; req = 3'b010;
    tick();
    req = 3'b011;
    tick();
    n_tests++;
    if (grant !== 3'b001 || preempted !== 1'b1 || nb_interrupts !== 16'd1 || grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL preempt_enter: grant=%b pre=%b nb=%0d id=%0d, want 001/1/1/1", grant, preempted, nb_interrupts, grant_id);
    end
    done = 3'b001; req = 3'b010;
    tick();
    n_tests++;
    if (grant !== 3'b010 || preempted !== 1'b0 || nb_interrupts !== 16'd1) begin
      n_fail++;
      $display("FAIL preempt_exit: grant=%b pre=%b nb=%0d, want 010/0/1", grant, preempted, nb_interrupts);
    end
    done = '0;
  endtask

  task automatic test_no_preempt();
    do_reset();
    preempt_en = 1'b0; req = 3'b010;
    tick();
    req = 3'b011;
    tick();
    n_tests++;
    if (grant !== 3'b010 || preempted !== 1'b0) begin
      n_fail++;
      $display("FAIL nopre_hold: grant=%b pre=%b, want 010/0", grant, preempted);
    end
    tick();
    n_tests++;
    if (grant !== 3'b001 || preempted !== 1'b0 || nb_interrupts !== 16'd0) begin
      n_fail++;
      $display("FAIL nopre_to_hp: grant=%b pre=%b nb=%0d, want 001/0/0", grant, preempted, nb_interrupts);
    end
  endtask

  task automatic test_nonowner_done();
    do_reset();
    req = 3'b010;
    tick();
    req = 3'b000; done = 3'b100;
    tick();
    n_tests++;
    if (grant !== 3'b010) begin
      n_fail++;
      $display("FAIL nonowner_done: grant=%b, want 010", grant);
    end
    done = 3'b000;
    tick();
    n_tests++;
    if (grant !== 3'b000) begin
      n_fail++;
      $display("FAIL hold_limit_idle: grant=%b, want 000", grant);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    preempt_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req = 3'b010; done = '0;
      tick();
      req = 3'b011;
      tick();
      req = 3'b000; done = 3'b001;
      tick();
    end
    done = '0;
    n_tests++;
    if (nb_sat !== 2'd3 || nb_interrupts !== 16'd5) begin
      n_fail++;
      $display("FAIL saturation: narrow=%0d wide=%0d, want 3/5", nb_sat, nb_interrupts);
    end
  endtask

  task automatic test_random();
    logic [2:0]  e_g;
    logic [1:0]  e_id;
    logic [15:0] e_nb;
    logic [1:0]  e_sat;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      done       = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      preempt_en = ($urandom_range(0, 3) != 0);
      reset_n    = ($urandom_range(0, 60) != 0);
      tick();
      model_step();
      e_g   = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
      e_id  = 2'(m_owner + 1);
      e_nb  = 16'(m_cnt);
      e_sat = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
      n_tests++;
      if (grant !== e_g || grant_id !== e_id || preempted !== m_pre) begin
        n_fail++;
        $display("FAIL rand_grant c%0d: grant=%b id=%0d pre=%b, want %b/%0d/%b", c, grant, grant_id, preempted, e_g, e_id, m_pre);
      end
      n_tests++;
      if (nb_interrupts !== e_nb || nb_sat !== e_sat || grant_s !== e_g) begin
        n_fail++;
        $display("FAIL rand_count c%0d: nb=%0d sat=%0d gs=%b, want %0d/%0d/%b", c, nb_interrupts, nb_sat, grant_s, e_nb, e_sat, e_g);
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; req = '0; done = '0; preempt_en = 1'b0;
    test_reset();
    test_hp_release_idle();
    test_round_robin();
    test_preempt();
    test_no_preempt();
    test_nonowner_done();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
